// File: rtl/match_search_ctrl.sv
// Sequential match-search controller: scans a small valid-tagged table through one shared
// external equality comparator. Optional build macro MULTI_HIT_EN selects full-scan match counting.
module match_search_ctrl #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clear,
    input  logic              start,
    input  logic [DATA_W-1:0] key,
    output logic [DATA_W-1:0] cmp_a,
    output logic [DATA_W-1:0] cmp_b,
    input  logic              cmp_eq,
    output logic              busy,
    output logic              done,
    output logic              hit,
    output logic [2:0]        hit_idx,
    output logic [3:0]        hit_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [IDX_W-1:0]  idx_r;
    logic [DATA_W-1:0] key_r;
    logic [DATA_W-1:0] entry_r [DEPTH];
    logic [DEPTH-1:0]  valid_r;
    logic              hit_r;
    logic [2:0]        hit_idx_r;
    logic [3:0]        hit_count_r;

    logic              scan_s;
    logic              match_s;
    logic              last_s;
    logic              term_s;
    logic              tbl_open_s;
    logic [IDX_W-1:0]  wr_idx_s;

    assign scan_s     = (state_r == ST_SCAN);
    assign tbl_open_s = ~scan_s;
    assign wr_idx_s   = wr_addr[IDX_W-1:0];
    assign last_s     = (idx_r == LAST_IDX);
    // An invalid entry must never count, even when the comparator reports equality.
    assign match_s    = scan_s & cmp_eq & valid_r[idx_r];

`ifdef MULTI_HIT_EN
    assign term_s = last_s;
`else
    assign term_s = last_s | match_s;
`endif

    assign cmp_a     = scan_s ? entry_r[idx_r] : {DATA_W{1'b0}};
    assign cmp_b     = scan_s ? key_r : {DATA_W{1'b0}};
    assign busy      = scan_s;
    assign done      = (state_r == ST_DONE);
    assign hit       = hit_r;
    assign hit_idx   = hit_idx_r;
    assign hit_count = hit_count_r;

    // Next-state decode for the IDLE/SCAN/DONE sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_SCAN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (term_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SCAN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Entry data storage; contents are left undefined by reset, only valid bits matter.
    always_ff @(posedge clk) begin
        if (tbl_open_s && wr_en && !clear) begin
            entry_r[wr_idx_s] <= wr_data;
        end
    end

    // Valid bits: clear wins over a same-cycle write, both are frozen while scanning.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {DEPTH{1'b0}};
        end else if (tbl_open_s) begin
            if (clear) begin
                valid_r <= {DEPTH{1'b0}};
            end else if (wr_en) begin
                valid_r[wr_idx_s] <= 1'b1;
            end
        end
    end

    // Scan control, key latch and result accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            idx_r       <= {IDX_W{1'b0}};
            key_r       <= {DATA_W{1'b0}};
            hit_r       <= 1'b0;
            hit_idx_r   <= 3'd0;
            hit_count_r <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        key_r       <= key;
                        idx_r       <= {IDX_W{1'b0}};
                        hit_r       <= 1'b0;
                        hit_idx_r   <= 3'd0;
                        hit_count_r <= 4'd0;
                    end
                end
                ST_SCAN: begin
                    if (match_s) begin
                        if (!hit_r) begin
                            hit_r     <= 1'b1;
                            hit_idx_r <= 3'(idx_r);
                        end
                        hit_count_r <= hit_count_r + 4'd1;
                    end
                    // The index stops at the final entry rather than wrapping.
                    if (!term_s) begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    idx_r <= idx_r;
                end
                default: begin
                    idx_r <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_match_search_ctrl.sv
// Self-checking bench for match_search_ctrl: timeline-based reference model plus directed cases
// with literal expectations; honours MULTI_HIT_EN the same way as the design.
module tb_match_search_ctrl;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       wr_en   = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [2:0] wr_data = 3'd0;
    logic       clear   = 1'b0;
    logic       start   = 1'b0;
    logic [2:0] key     = 3'd0;
    logic [2:0] cmp_a;
    logic [2:0] cmp_b;
    logic       cmp_eq;
    logic       busy;
    logic       done;
    logic       hit;
    logic [2:0] hit_idx;
    logic [3:0] hit_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // External 3-bit equality comparator.
    assign cmp_eq = (cmp_a == cmp_b);

    match_search_ctrl #(.DEPTH(8), .DATA_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clear(clear), .start(start), .key(key), .cmp_a(cmp_a), .cmp_b(cmp_b),
        .cmp_eq(cmp_eq), .busy(busy), .done(done), .hit(hit), .hit_idx(hit_idx),
        .hit_count(hit_count)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a search is a timeline of m_term+1 scan cycles then one done cycle.
    logic [2:0] m_tbl [8];
    logic [7:0] m_valid = 8'h00;
    logic [7:0] m_known = 8'h00;
    bit         m_active = 1'b0;
    int         m_k = 0;
    int         m_term = 0;
    bit         m_hit = 1'b0;
    int         m_idx = 0;
    int         m_cnt = 0;
    logic [2:0] m_key = 3'd0;

    always @(posedge clk or negedge rst_n) begin : model
        logic [2:0] nt [8];
        logic [7:0] nv;
        logic [7:0] nk;
        int first;
        int cnt;
        if (!rst_n) begin
            m_valid  <= 8'h00;
            m_active <= 1'b0;
            m_k      <= 0;
            m_term   <= 0;
            m_hit    <= 1'b0;
            m_idx    <= 0;
            m_cnt    <= 0;
            m_key    <= 3'd0;
        end else begin
            nt = m_tbl;
            nv = m_valid;
            nk = m_known;
            if (!(m_active && m_k <= m_term + 1)) begin
                if (clear) begin
                    nv = 8'h00;
                end else if (wr_en) begin
                    nt[wr_addr] = wr_data;
                    nv[wr_addr] = 1'b1;
                    nk[wr_addr] = 1'b1;
                end
            end
            m_tbl   <= nt;
            m_valid <= nv;
            m_known <= nk;
            if (!m_active && start) begin
                first = -1;
                cnt   = 0;
                for (int i = 0; i < 8; i++) begin
                    if (nv[i] && nt[i] == key) begin
                        cnt++;
                        if (first < 0) first = i;
                    end
                end
                m_key    <= key;
                m_active <= 1'b1;
                m_k      <= 1;
                m_hit    <= (first >= 0);
                m_idx    <= (first >= 0) ? first : 0;
`ifdef MULTI_HIT_EN
                m_cnt    <= cnt;
                m_term   <= 7;
`else
                m_cnt    <= (first >= 0) ? 1 : 0;
                m_term   <= (first >= 0) ? first : 7;
`endif
            end else if (m_active) begin
                if (m_k >= m_term + 2) m_active <= 1'b0;
                else m_k <= m_k + 1;
            end
        end
    end

    always @(negedge clk) begin : compare
        bit sc;
        bit dn;
        if (rst_n) begin
            sc = m_active && (m_k <= m_term + 1);
            dn = m_active && (m_k == m_term + 2);
            chk("busy", int'(busy), int'(sc));
            chk("done", int'(done), int'(dn));
            if (sc) begin
                chk("cmp_b", int'(cmp_b), int'(m_key));
                if (m_known[m_k-1]) chk("cmp_a", int'(cmp_a), int'(m_tbl[m_k-1]));
            end else begin
                chk("cmp_a_idle", int'(cmp_a), 0);
                chk("cmp_b_idle", int'(cmp_b), 0);
                chk("hit", int'(hit), int'(m_hit));
                chk("hit_idx", int'(hit_idx), m_idx);
                chk("hit_count", int'(hit_count), m_cnt);
            end
        end
    end

    task automatic wr(input logic [2:0] a, input logic [2:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic load_table();
        logic [2:0] vals [8];
        vals = '{3'd5, 3'd1, 3'd3, 3'd3, 3'd7, 3'd0, 3'd2, 3'd6};
        for (int i = 0; i < 8; i++) wr(3'(i), vals[i]);
    endtask

    // Returns the start-to-done latency in cycles, or -1 if done never arrives.
    task automatic wait_done(input int from, output int lat);
        lat = -1;
        for (int n = from; n <= 30; n++) begin
            if (done) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic search(input logic [2:0] k, output int lat);
        @(negedge clk);
        start = 1'b1; key = k;
        @(negedge clk);
        start = 1'b0;
        wait_done(1, lat);
    endtask

    initial begin : stim
        int lat;
        int full_lat;
        int key3_lat;
        int key3_cnt;
`ifdef MULTI_HIT_EN
        key3_lat = 9; key3_cnt = 2;
`else
        key3_lat = 4; key3_cnt = 1;
`endif
        full_lat = 9;

        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_hit", int'(hit), 0);
        chk("rst_hit_idx", int'(hit_idx), 0);
        chk("rst_hit_count", int'(hit_count), 0);
        chk("rst_cmp_a", int'(cmp_a), 0);
        chk("rst_cmp_b", int'(cmp_b), 0);
        rst_n = 1'b1;

        load_table();
        search(3'd3, lat);
        chk("k3_latency", lat, key3_lat);
        chk("k3_hit", int'(hit), 1);
        chk("k3_hit_idx", int'(hit_idx), 2);
        chk("k3_hit_count", int'(hit_count), key3_cnt);
        repeat (3) @(negedge clk);
        chk("k3_hold_hit_idx", int'(hit_idx), 2);

        search(3'd4, lat);
        chk("k4_latency", lat, full_lat);
        chk("k4_hit", int'(hit), 0);
        chk("k4_hit_count", int'(hit_count), 0);

        do_clear();
        search(3'd0, lat);
        chk("clr_latency", lat, full_lat);
        chk("clr_hit", int'(hit), 0);

        // Write and second start landing in scan cycle 2 must both be ignored.
        load_table();
        @(negedge clk);
        start = 1'b1; key = 3'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 3'd4; start = 1'b1; key = 3'd6;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        wait_done(3, lat);
        chk("drop_latency", lat, full_lat);
        chk("drop_hit", int'(hit), 0);
        repeat (3) @(negedge clk);
        chk("drop_no_restart", int'(busy), 0);
        search(3'd6, lat);
        chk("drop_e7_hit", int'(hit), 1);
        chk("drop_e7_idx", int'(hit_idx), 7);

        // Reset asserted in scan cycle 3.
        @(negedge clk);
        start = 1'b1; key = 3'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_hit", int'(hit), 0);
        chk("mid_rst_hit_count", int'(hit_count), 0);
        chk("mid_rst_cmp_b", int'(cmp_b), 0);
        @(negedge clk);
        rst_n = 1'b1;
        search(3'd5, lat);
        chk("post_rst_latency", lat, full_lat);
        chk("post_rst_hit5", int'(hit), 0);
        search(3'd3, lat);
        chk("post_rst_hit3", int'(hit), 0);

        // Randomised traffic against the model.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = 3'($urandom_range(0, 7));
            clear   = ($urandom_range(0, 40) == 0);
            start   = ($urandom_range(0, 3) == 0);
            key     = 3'($urandom_range(0, 7));
        end
        @(negedge clk);
        wr_en = 1'b0; clear = 1'b0; start = 1'b0;
        repeat (12) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/match_search_ctrl.md
MATCH_SEARCH_CTRL -- requirements
Module: match_search_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of table entries (power of 2, 2..8).
REQ-002 SHALL have parameter DATA_W, default 3, meaning entry/key width matching the shared 3-bit equality comparator.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port wr_en, input, 1, meaning table write strobe.
REQ-006 SHALL have port wr_addr, input, 3, meaning write entry index.
REQ-007 SHALL have port wr_data, input, DATA_W, meaning write entry value.
REQ-008 SHALL have port clear, input, 1, meaning invalidate all entries.
REQ-009 SHALL have port start, input, 1, meaning search request.
REQ-010 SHALL have port key, input, DATA_W, meaning search key, sampled with start.
REQ-011 SHALL have port cmp_a, output, DATA_W, meaning comparator operand A (current entry).
REQ-012 SHALL have port cmp_b, output, DATA_W, meaning comparator operand B (latched key).
REQ-013 SHALL have port cmp_eq, input, 1, meaning combinational Equal result from the external comparator.
REQ-014 SHALL have port busy, output, 1, meaning scan in progress.
REQ-015 SHALL have port done, output, 1, meaning one-cycle search-complete pulse.
REQ-016 SHALL have port hit, output, 1, meaning at least one valid entry matched.
REQ-017 SHALL have port hit_idx, output, 3, meaning index of first matching entry.
REQ-018 SHALL have port hit_count, output, 4, meaning number of matching valid entries.

Function
REQ-019 SHALL implement FSM states IDLE, SCAN, DONE; IDLE->SCAN on start, SCAN->DONE on termination, DONE->IDLE unconditionally.
REQ-020 SHALL, on start in IDLE, latch key into key_q, set scan index to 0, and clear hit, hit_idx and hit_count.
REQ-021 SHALL drive cmp_a = entry[idx] and cmp_b = key_q in SCAN; both SHALL be 0 outside SCAN.
REQ-022 SHALL treat a SCAN cycle as a match only if cmp_eq=1 and entry[idx] is valid.
REQ-023 SHALL, on the first match, set hit=1 and hit_idx=idx.
REQ-024 SHALL terminate the scan at idx=DEPTH-1 if no earlier termination occurs; idx SHALL never wrap.
REQ-025 SHALL assert busy only in SCAN and done only in DONE, for exactly one cycle.
REQ-026 SHALL hold hit, hit_idx and hit_count stable from DONE until the next accepted start.
REQ-027 SHALL ignore start outside IDLE.
REQ-028 SHALL accept wr_en (entry written, valid set) only when not busy; writes during SCAN SHALL be dropped.
REQ-029 SHALL apply clear (all valid bits 0) only when not busy; clear SHALL take priority over wr_en in the same cycle.
REQ-030 SHALL, for wr_en or clear together with start in IDLE, apply the table update before the scan, so the scan sees the updated table.
REQ-031 SHALL give start-to-done latency of i+2 cycles for early termination at index i, and DEPTH+1 cycles for a full scan.

Reset
REQ-032 SHALL, on rst_n=0, immediately force IDLE, clear all valid bits, and set busy, done, hit, hit_idx, hit_count, cmp_a, cmp_b and key_q to 0, including mid-scan.
REQ-033 SHALL leave entry data contents unspecified after reset; only the valid bits are defined.

Configuration
REQ-034 SHALL support macro MULTI_HIT_EN.
- Defined: scan always covers all DEPTH entries; hit_count = number of matches; hit_idx = first match.
- Undefined: scan terminates on the first match; hit_count = hit (0 or 1).

Verification
REQ-035 SHALL cover: write entries 0..7 = 5,1,3,3,7,0,2,6, start with key=3 (MULTI_HIT_EN off) -> done 4 cycles after start, hit=1, hit_idx=2, hit_count=1.
REQ-036 SHALL cover: same table and key with MULTI_HIT_EN on -> done 9 cycles after start, hit=1, hit_idx=2, hit_count=2.
REQ-037 SHALL cover: key=4 on the same table -> done 9 cycles after start, hit=0, hit_count=0.
REQ-038 SHALL cover: clear, then key=0 with entry data 0 -> hit=0 (invalid entries never match despite cmp_eq=1).
REQ-039 SHALL cover: wr_en to entry 7 and a second start issued in SCAN cycle 2 -> write dropped and start ignored; results reflect the original table only.
REQ-040 SHALL cover: rst_n low in SCAN cycle 3 -> busy=0, done=0, hit=0 immediately; a following search of any key -> hit=0.
